// File: rtl/bibus_master.sv
// Bidirectional-bus master: runs one read or write per command,
// with a turnaround gap whenever the transfer direction flips.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_write           1 = write, 0 = read
//   cmd_sel             read device select (0 = none, error read)
//   cmd_addr/wdata      transaction address and write data
//   sel1..sel3          one-hot device read selects
//   addr                bus address, held while idle
//   data_bus            shared tri-state data bus
//   wr_en               high while the master drives data_bus
//   rsp_valid           one-cycle response pulse
//   rsp_write/data/err  response type, data and error flag
module bibus_master #(
  parameter int WAIT_CYCLES = 1,
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic [7:0] addr,
  inout  wire  [7:0] data_bus,
  output logic       wr_en,
  output logic       rsp_valid,
  output logic       rsp_write,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    WRITE,
    READ
  } state_t;

  localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       op_done;
  logic       enter_op;
  logic       rd;

  logic       wr_q;
  logic [1:0] sel_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;

  // Direction of the last completed command; dir_vld is
  // cleared by reset so the first command skips turnaround.
  logic       dir_vld;
  logic       dir_wr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (dir_vld && (dir_wr != cmd_write)) begin
            state_nxt = TURN;
            cnt_nxt   = TURN_LD;
          end else if (cmd_write) begin
            state_nxt = WRITE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = READ;
            cnt_nxt   = WAIT_LD;
          end
        end
      end
      TURN: begin
        if (cnt == '0) begin
          if (wr_q) begin
            state_nxt = WRITE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = READ;
            cnt_nxt   = WAIT_LD;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        op_done   = 1'b1;
      end
      READ: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          op_done   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // addr only moves when an operation state is entered, so
  // it keeps the previous address through IDLE and TURN.
  assign enter_op = ((state_nxt == WRITE) ||
                     (state_nxt == READ)) &&
                    ((state == IDLE) || (state == TURN));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dir_vld   <= 1'b0;
      dir_wr    <= 1'b0;
      wr_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      addr      <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= op_done;
      if (cmd_valid && cmd_ready) begin
        wr_q    <= cmd_write;
        sel_q   <= cmd_sel;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (enter_op) begin
        addr <= (state == IDLE) ? cmd_addr : addr_q;
      end
      if (op_done) begin
        dir_vld   <= 1'b1;
        dir_wr    <= wr_q;
        rsp_write <= wr_q;
        rsp_err   <= !wr_q && (sel_q == 2'd0);
        if (wr_q) begin
          rsp_data <= wdata_q;
        end else if (sel_q == 2'd0) begin
          rsp_data <= 8'h00;
        end else begin
          rsp_data <= data_bus;
        end
      end
    end
  end

  assign cmd_ready = (state == IDLE);
  assign wr_en     = (state == WRITE);
  assign rd        = (state == READ);
  assign sel1      = rd && (sel_q == 2'd1);
  assign sel2      = rd && (sel_q == 2'd2);
  assign sel3      = rd && (sel_q == 2'd3);
  assign data_bus  = wr_en ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_bibus_master.sv
// Randomized bench for bibus_master against a latency/data model.
// A second instance runs with WAIT_CYCLES=0, TURN_CYCLES=2.
module tb_bibus_master;

  localparam int W = 1;
  localparam int T = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [1:0] cmd_sel   = '0;
  logic [7:0] cmd_addr  = '0;
  logic [7:0] cmd_wdata = '0;
  wire        cmd_ready;
  wire        sel1, sel2, sel3;
  wire  [7:0] addr;
  wire  [7:0] data_bus;
  wire        wr_en;
  wire        rsp_valid, rsp_write, rsp_err;
  wire  [7:0] rsp_data;
  logic [7:0] dev_val = '0;

  assign data_bus = (sel1 | sel2 | sel3) ? dev_val : 8'hzz;

  bibus_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_sel   (cmd_sel),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel3      (sel3),
    .addr      (addr),
    .data_bus  (data_bus),
    .wr_en     (wr_en),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  logic       c0_valid = 1'b0;
  logic       c0_write = 1'b0;
  logic [1:0] c0_sel   = '0;
  logic [7:0] c0_addr  = '0;
  logic [7:0] c0_wdata = '0;
  wire        c0_ready;
  wire        s0_1, s0_2, s0_3;
  wire  [7:0] addr0;
  wire  [7:0] bus0;
  wire        wr_en0;
  wire        r0_valid, r0_write, r0_err;
  wire  [7:0] r0_data;

  assign bus0 = (s0_1 | s0_2 | s0_3) ? 8'hC3 : 8'hzz;

  bibus_master #(
    .WAIT_CYCLES (0),
    .TURN_CYCLES (2)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (c0_valid),
    .cmd_ready (c0_ready),
    .cmd_write (c0_write),
    .cmd_sel   (c0_sel),
    .cmd_addr  (c0_addr),
    .cmd_wdata (c0_wdata),
    .sel1      (s0_1),
    .sel2      (s0_2),
    .sel3      (s0_3),
    .addr      (addr0),
    .data_bus  (bus0),
    .wr_en     (wr_en0),
    .rsp_valid (r0_valid),
    .rsp_write (r0_write),
    .rsp_data  (r0_data),
    .rsp_err   (r0_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("one_sel",
          32'($countones({sel1, sel2, sel3}) <= 1), 1);
      chk("sel_wr",
          32'(wr_en && (sel1 | sel2 | sel3)), 0);
      chk("one_sel0",
          32'($countones({s0_1, s0_2, s0_3}) <= 1), 1);
      chk("sel_wr0",
          32'(wr_en0 && (s0_1 | s0_2 | s0_3)), 0);
    end
  end

  // Reference model state
  bit         have_last = 0;
  bit         last_wr   = 0;
  logic [7:0] last_addr = '0;
  logic [7:0] exp_rdata = '0;

  // Must be called at a negedge; returns at the negedge of
  // the rsp_valid cycle so back-to-back issue is possible.
  task automatic issue(input bit w, input logic [1:0] s,
                       input logic [7:0] a,
                       input logic [7:0] d);
    int lat, exp_lat, turn, first_op;
    int sel_cnt, wr_cnt, guard;
    logic [7:0] exp_d;
    turn    = (have_last && (last_wr != w)) ? T : 0;
    exp_lat = (w ? 2 : 2 + W) + turn;
    exp_d   = w ? d : ((s == 2'd0) ? 8'h00 : dev_val);
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_sel   = s;
    cmd_addr  = a;
    cmd_wdata = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_sel   = 2'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);
    lat = 0; first_op = 0; sel_cnt = 0; wr_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (wr_en) begin
        wr_cnt++;
        if (first_op == 0) first_op = lat;
        chk("wdata", 32'(data_bus), 32'(d));
        chk("waddr", 32'(addr), 32'(a));
      end else if (sel1 | sel2 | sel3) begin
        sel_cnt++;
        if (first_op == 0) first_op = lat;
        chk("sel_which", 32'({sel3, sel2, sel1}),
            32'(1) << (s - 2'd1));
        chk("raddr", 32'(addr), 32'(a));
      end
      if (lat <= turn) begin
        chk("turn_addr", 32'(addr), 32'(last_addr));
        chk("turn_idle", 32'(wr_en | sel1 | sel2 | sel3), 0);
      end
      if (!rsp_valid) begin
        chk("busy", 32'(cmd_ready), 0);
        chk("hold_data", 32'(rsp_data), 32'(exp_rdata));
      end
    end while (!rsp_valid && lat < 40);
    chk("latency", lat, exp_lat);
    chk("rsp_write", 32'(rsp_write), 32'(w));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("rsp_err", 32'(rsp_err), 32'(!w && s == 2'd0));
    chk("rsp_ready", 32'(cmd_ready), 1);
    if (w) begin
      chk("wr_cycles", wr_cnt, 1);
      chk("wr_start", first_op, turn + 1);
    end else if (s != 2'd0) begin
      chk("rd_cycles", sel_cnt, W + 1);
      chk("rd_start", first_op, turn + 1);
    end else begin
      chk("nosel", sel_cnt, 0);
    end
    have_last = 1;
    last_wr   = w;
    last_addr = a;
    exp_rdata = exp_d;
  endtask

  task automatic run0(input bit w, input logic [1:0] s,
                      input int exp_lat,
                      input logic [7:0] exp_d);
    int lat, guard;
    guard = 0;
    while (!c0_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("r0_ready", 32'(c0_ready), 1);
    c0_valid = 1'b1;
    c0_write = w;
    c0_sel   = s;
    c0_addr  = 8'($urandom);
    c0_wdata = exp_d;
    @(posedge clk);
    #1;
    c0_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!r0_valid && lat < 40);
    chk("r0_latency", lat, exp_lat);
    chk("r0_data", 32'(r0_data), 32'(exp_d));
    chk("r0_write", 32'(r0_write), 32'(w));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_sel", 32'({sel1, sel2, sel3}), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_write", 32'(rsp_write), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    rst = 1'b1;

    dev_val = 8'hA5;
    issue(1'b0, 2'd2, 8'h3C, 8'h00);
    issue(1'b1, 2'd0, 8'h41, 8'h5A);
    issue(1'b1, 2'd3, 8'h42, 8'h66);
    issue(1'b0, 2'd0, 8'h43, 8'h00);
    dev_val = 8'h19;
    issue(1'b0, 2'd1, 8'h44, 8'h00);

    // Reset in the first select cycle of a read
    dev_val = 8'hE7;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_sel   = 2'd3;
    cmd_addr  = 8'h77;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_sel_on", 32'(sel3), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_sel_off", 32'({sel1, sel2, sel3}), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_rsp", 32'(rsp_valid), 0);
    chk("abort_data", 32'(rsp_data), 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_norsp", 32'(rsp_valid), 0);
    end
    have_last = 0;
    last_addr = '0;
    exp_rdata = '0;
    issue(1'b1, 2'd0, 8'h90, 8'hC8);

    repeat (80) begin
      dev_val = 8'($urandom);
      issue(1'($urandom), 2'($urandom),
            8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    run0(1'b0, 2'd1, 2, 8'hC3);
    run0(1'b0, 2'd3, 2, 8'hC3);
    run0(1'b1, 2'd0, 4, 8'h77);
    run0(1'b1, 2'd2, 2, 8'h12);
    run0(1'b0, 2'd0, 4, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
